axi4_rd_arbiter: RTL

//  Round-robin arbiter that shares one AXI4 read slave (AR + R channels) between NUM_M read masters.
//  It sits between the test masters/DMA ports and the single AXI4 memory slave.
//  One burst is outstanding at a time: the grant is held from AR arbitration until the R beat with RLAST.

---
 rtl/axi4_rd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_rd_arbiter
// Description : Round-robin arbiter sharing one AXI4 read slave (AR + R)
//               between NUM_M masters, one burst outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_rd_arbiter #(
    parameter int NUM_M      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_M-1:0]            M_ARVALID,
    output logic [NUM_M-1:0]            M_ARREADY,
    input  logic [NUM_M*ADDR_WIDTH-1:0] M_ARADDR,
    input  logic [NUM_M*8-1:0]          M_ARLEN,
    input  logic [NUM_M*3-1:0]          M_ARSIZE,
    output logic [NUM_M-1:0]            M_RVALID,
    input  logic [NUM_M-1:0]            M_RREADY,
    output logic [DATA_WIDTH-1:0]       M_RDATA,
    output logic [1:0]                  M_RRESP,
    output logic                        M_RLAST,
    output logic                        S_ARVALID,
    input  logic                        S_ARREADY,
    output logic [ADDR_WIDTH-1:0]       S_ARADDR,
    output logic [7:0]                  S_ARLEN,
    output logic [2:0]                  S_ARSIZE,
    input  logic                        S_RVALID,
    output logic                        S_RREADY,
    input  logic [DATA_WIDTH-1:0]       S_RDATA,
    input  logic [1:0]                  S_RRESP,
    input  logic                        S_RLAST,
    output logic [NUM_M-1:0]            GRANT
);

    localparam int                 c_IDX_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_M - 1);
    localparam logic [c_IDX_W:0]   c_NUM_M    = (c_IDX_W + 1)'(NUM_M);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_grant_idx;
    logic [c_IDX_W-1:0]    w_grant_idx_nxt;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    w_rr_ptr_nxt;
    logic [c_IDX_W-1:0]    w_pick;
    logic                  w_found;
    logic [c_IDX_W:0]      w_scan;

    logic [ADDR_WIDTH-1:0] w_araddr [NUM_M];
    logic [7:0]            w_arlen  [NUM_M];
    logic [2:0]            w_arsize [NUM_M];

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_slice
            assign w_araddr[gi] = M_ARADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_arlen[gi]  = M_ARLEN[gi*8 +: 8];
            assign w_arsize[gi] = M_ARSIZE[gi*3 +: 3];
        end
    endgenerate

    // First requester at or above the round-robin pointer, wrapping at NUM_M.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_scan >= c_NUM_M) begin
                w_scan = w_scan - c_NUM_M;
            end
            if (!w_found && M_ARVALID[w_scan[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[c_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= c_ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = c_ST_ADDR;
                    w_grant_idx_nxt = w_pick;
                end
            end
            c_ST_ADDR: begin
                if (M_ARVALID[r_grant_idx] && S_ARREADY) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                // Only RLAST ends the burst; beats are not counted.
                if (S_RVALID && M_RREADY[r_grant_idx] && S_RLAST) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_rr_ptr_nxt = (r_grant_idx == c_LAST_IDX) ? '0 : r_grant_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        M_ARREADY = '0;
        M_RVALID  = '0;
        S_ARVALID = 1'b0;
        S_ARADDR  = '0;
        S_ARLEN   = '0;
        S_ARSIZE  = '0;
        S_RREADY  = 1'b0;
        GRANT     = '0;
        case (r_state)
            c_ST_ADDR: begin
                GRANT[r_grant_idx]     = 1'b1;
                S_ARVALID              = M_ARVALID[r_grant_idx];
                S_ARADDR               = w_araddr[r_grant_idx];
                S_ARLEN                = w_arlen[r_grant_idx];
                S_ARSIZE               = w_arsize[r_grant_idx];
                M_ARREADY[r_grant_idx] = S_ARREADY;
            end
            c_ST_DATA: begin
                GRANT[r_grant_idx]    = 1'b1;
                M_RVALID[r_grant_idx] = S_RVALID;
                S_RREADY              = M_RREADY[r_grant_idx];
            end
            default: begin
            end
        endcase
    end

    // Payload is broadcast; M_RVALID alone selects the receiving master.
    assign M_RDATA = S_RDATA;
    assign M_RRESP = S_RRESP;
    assign M_RLAST = S_RLAST;

endmodule
`default_nettype wire
